// File: rtl/packet_bch_serializer_pkg.sv
// Shared constants, types and the BCH step function for the data-island packet serializer.
package packet_bch_serializer_pkg;

    localparam logic [7:0] ECC_POLY = 8'b1000_0011;

    localparam int HEADER_W = 24;
    localparam int SUB_W    = 56;
    localparam int NUM_SUBS = 4;

    typedef logic [HEADER_W-1:0] header_t;
    typedef logic [SUB_W-1:0]    subpacket_t;

    // Bit positions inside packet_data = {ch2[3:0], ch1[3:0], ch0_bit2}
    localparam int LANE_CH0_BIT2 = 0;
    localparam int LANE_CH1      = 1;
    localparam int LANE_CH2      = 5;

    function automatic logic [7:0] next_ecc(input logic [7:0] e, input logic b);
        return (e >> 1) ^ ((e[0] ^ b) ? ECC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/packet_bch_serializer_bch_lane.sv
// One serial lane: shifts out BITS data bits per pixel while folding them into a BCH
// accumulator, then shifts out the 8 parity bits for the remaining pixels.
module bch_lane
    import packet_bch_serializer_pkg::*;
#(
    parameter int BITS   = 1,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              load,
    input  logic [4:0]        counter,
    input  logic [DATA_W-1:0] data,
    output logic [BITS-1:0]   lane_bits
);

    localparam int DATA_PIXELS = DATA_W / BITS;

    logic [DATA_W-1:0] shift_reg, shift_next, source;
    logic [7:0]        ecc_reg, ecc_next, ecc_seed;
    logic              data_phase;

    always_comb begin
        data_phase = counter < 5'(DATA_PIXELS);
        // On a load the first bits come straight from the input and prior parity is dropped
        source     = load ? data : shift_reg;
        ecc_seed   = load ? 8'h00 : ecc_reg;
        shift_next = source >> BITS;
        lane_bits  = source[BITS-1:0];
        ecc_next   = ecc_seed;
        if (data_phase) begin
            for (int i = 0; i < BITS; i++) begin
                ecc_next = next_ecc(ecc_next, source[i]);
            end
        end else begin
            lane_bits = ecc_reg[BITS-1:0];
            ecc_next  = ecc_reg >> BITS;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_reg <= '0;
            ecc_reg   <= '0;
        end else if (enable) begin
            shift_reg <= shift_next;
            ecc_reg   <= ecc_next;
        end
    end

endmodule

// File: rtl/packet_bch_serializer.sv
// Serializes one HDMI data-island packet plus BCH parity over 32 pixels into the
// per-pixel nibble stream, and provides the packet counter and boundary strobe.
module packet_bch_serializer
    import packet_bch_serializer_pkg::*;
#(
    parameter int PACKET_PIXELS = 32
) (
    input  logic                       clk_pixel,
    input  logic                       reset_n,
    input  logic                       data_island_period,
    input  header_t                    header,
    input  subpacket_t [NUM_SUBS-1:0]  sub,
    output logic [4:0]                 packet_pixel_counter,
    output logic                       packet_enable,
    output logic [8:0]                 packet_data,
    output logic                       first_pixel_n
);

    logic [4:0]          counter_reg;
    logic [8:0]          packet_data_reg, packet_data_next;
    logic                first_pixel_n_reg;
    logic                load;
    logic                header_bit;
    logic [NUM_SUBS-1:0] ch1, ch2;
    logic [1:0]          sub_bits [NUM_SUBS];

    assign load                 = data_island_period && (counter_reg == 5'd0);
    assign packet_enable        = data_island_period && (counter_reg == 5'(PACKET_PIXELS - 1));
    assign packet_pixel_counter = counter_reg;
    assign packet_data          = packet_data_reg;
    assign first_pixel_n        = first_pixel_n_reg;

    bch_lane #(.BITS(1), .DATA_W(HEADER_W)) u_header_lane (
        .clk       (clk_pixel),
        .reset_n   (reset_n),
        .enable    (data_island_period),
        .load      (load),
        .counter   (counter_reg),
        .data      (header),
        .lane_bits (header_bit)
    );

    generate
        for (genvar gi = 0; gi < NUM_SUBS; gi++) begin : g_sub_lane
            bch_lane #(.BITS(2), .DATA_W(SUB_W)) u_sub_lane (
                .clk       (clk_pixel),
                .reset_n   (reset_n),
                .enable    (data_island_period),
                .load      (load),
                .counter   (counter_reg),
                .data      (sub[gi]),
                .lane_bits (sub_bits[gi])
            );
            assign ch1[gi] = sub_bits[gi][0];
            assign ch2[gi] = sub_bits[gi][1];
        end
    endgenerate

    always_comb begin
        packet_data_next                       = '0;
        packet_data_next[LANE_CH0_BIT2]        = header_bit;
        packet_data_next[LANE_CH1 +: NUM_SUBS] = ch1;
        packet_data_next[LANE_CH2 +: NUM_SUBS] = ch2;
    end

    // The 5-bit counter wraps 31->0 by itself, giving gapless back-to-back packets
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            counter_reg       <= '0;
            packet_data_reg   <= '0;
            first_pixel_n_reg <= 1'b0;
        end else if (!data_island_period) begin
            counter_reg       <= '0;
            packet_data_reg   <= '0;
            first_pixel_n_reg <= 1'b0;
        end else begin
            counter_reg       <= counter_reg + 5'd1;
            packet_data_reg   <= packet_data_next;
            first_pixel_n_reg <= (counter_reg != 5'd0);
        end
    end

endmodule

// File: tb/tb_packet_bch_serializer.sv
// Self-checking bench: directed packets plus randomized packets against a whole-packet BCH model.
module tb_packet_bch_serializer;

    logic             clk_pixel = 1'b0;
    logic             reset_n;
    logic             data_island_period;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic [4:0]       packet_pixel_counter;
    logic             packet_enable;
    logic [8:0]       packet_data;
    logic             first_pixel_n;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_words [32];

    always #5 clk_pixel = ~clk_pixel;

    packet_bch_serializer dut (
        .clk_pixel            (clk_pixel),
        .reset_n              (reset_n),
        .data_island_period   (data_island_period),
        .header               (header),
        .sub                  (sub),
        .packet_pixel_counter (packet_pixel_counter),
        .packet_enable        (packet_enable),
        .packet_data          (packet_data),
        .first_pixel_n        (first_pixel_n)
    );

    function automatic logic [55:0] rand56();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[55:0];
    endfunction

    // Parity of a whole bit sequence, bit 0 first
    function automatic logic [7:0] bch_of(input logic [55:0] bits, input int n);
        logic [7:0] e;
        logic       fb;
        e = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb = e[0] ^ bits[i];
            e  = e >> 1;
            if (fb) e = e ^ 8'h83;
        end
        return e;
    endfunction

    // Expected 32-pixel word stream for a complete packet
    task automatic build_model(input logic [23:0] hdr, input logic [3:0][55:0] sb);
        logic [7:0] he;
        logic [7:0] se [4];
        logic [8:0] w;
        he = bch_of({32'h0, hdr}, 24);
        for (int k = 0; k < 4; k++) se[k] = bch_of(sb[k], 56);
        for (int c = 0; c < 32; c++) begin
            w    = '0;
            w[0] = (c < 24) ? hdr[c] : he[c-24];
            for (int k = 0; k < 4; k++) begin
                w[1+k] = (c < 28) ? sb[k][2*c]   : se[k][2*(c-28)];
                w[5+k] = (c < 28) ? sb[k][2*c+1] : se[k][2*(c-28)+1];
            end
            exp_words[c] = w;
        end
    endtask

    task automatic random_packet(output logic [23:0] hdr, output logic [3:0][55:0] sb);
        hdr = 24'($urandom());
        for (int k = 0; k < 4; k++) sb[k] = rand56();
    endtask

    task automatic scramble_inputs();
        header = 24'($urandom());
        for (int k = 0; k < 4; k++) sub[k] = rand56();
    endtask

    // Drives one full packet starting at counter 0 and checks all 32 pixels against exp_words
    task automatic run_packet(input logic [23:0] hdr, input logic [3:0][55:0] sb, input string name);
        int bad_before;
        bad_before = bad;
        for (int c = 0; c < 32; c++) begin
            data_island_period = 1'b1;
            if (c == 0) begin
                header = hdr;
                sub    = sb;
            end else begin
                scramble_inputs();
            end
            #1;
            total++;
            if (packet_pixel_counter !== 5'(c)) begin
                bad++;
                $display("FAIL %s counter pixel %0d got=%0d want=%0d", name, c, packet_pixel_counter, c);
            end
            total++;
            if (packet_enable !== (c == 31)) begin
                bad++;
                $display("FAIL %s packet_enable pixel %0d got=%b want=%b", name, c, packet_enable, (c == 31));
            end
            @(posedge clk_pixel); #1;
            total++;
            if (packet_data !== exp_words[c]) begin
                bad++;
                $display("FAIL %s packet_data pixel %0d got=%h want=%h", name, c, packet_data, exp_words[c]);
            end
            total++;
            if (first_pixel_n !== (c != 0)) begin
                bad++;
                $display("FAIL %s first_pixel_n pixel %0d got=%b want=%b", name, c, first_pixel_n, (c != 0));
            end
        end
        $display("packet %s hdr=%h sub0=%h errors=%0d", name, hdr, sb[0], bad - bad_before);
    endtask

    // Runs the first n pixels of a packet without checking the data
    task automatic advance(input logic [23:0] hdr, input logic [3:0][55:0] sb, input int n);
        for (int c = 0; c < n; c++) begin
            data_island_period = 1'b1;
            if (c == 0) begin
                header = hdr;
                sub    = sb;
            end else begin
                scramble_inputs();
            end
            @(posedge clk_pixel); #1;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if (packet_pixel_counter !== 5'd0) begin
            bad++;
            $display("FAIL %s counter got=%0d want=0", name, packet_pixel_counter);
        end
        total++;
        if (packet_data !== 9'h000) begin
            bad++;
            $display("FAIL %s packet_data got=%h want=000", name, packet_data);
        end
        total++;
        if (first_pixel_n !== 1'b0) begin
            bad++;
            $display("FAIL %s first_pixel_n got=%b want=0", name, first_pixel_n);
        end
        total++;
        if (packet_enable !== 1'b0) begin
            bad++;
            $display("FAIL %s packet_enable got=%b want=0", name, packet_enable);
        end
    endtask

    task automatic test_reset();
        reset_n            = 1'b0;
        data_island_period = 1'b1;
        scramble_inputs();
        repeat (3) @(posedge clk_pixel);
        #1;
        check_idle_outputs("reset");
        data_island_period = 1'b0;
        reset_n            = 1'b1;
        @(posedge clk_pixel); #1;
        check_idle_outputs("post_reset_idle");
        $display("reset checked");
    endtask

    task automatic test_null();
        for (int c = 0; c < 32; c++) exp_words[c] = 9'h000;
        run_packet(24'h0, '0, "null");
    endtask

    task automatic test_header_msb();
        logic [7:0] parity;
        parity = 8'h83;
        for (int c = 0; c < 32; c++) exp_words[c] = 9'h000;
        exp_words[23] = 9'h001;
        for (int i = 0; i < 8; i++) exp_words[24+i] = {8'h00, parity[i]};
        run_packet(24'h800000, '0, "header_msb");
    endtask

    task automatic test_sub_msb();
        logic [3:0][55:0] sb;
        sb = '0;
        sb[0][55] = 1'b1;
        for (int c = 0; c < 32; c++) exp_words[c] = 9'h000;
        exp_words[27] = 9'h020;
        exp_words[28] = 9'h022;
        exp_words[31] = 9'h020;
        run_packet(24'h0, sb, "sub0_msb");
    endtask

    task automatic test_back_to_back();
        logic [23:0]      hdr;
        logic [3:0][55:0] sb;
        random_packet(hdr, sb);
        build_model(hdr, sb);
        run_packet(hdr, sb, "b2b_first");
        for (int k = 0; k < 4; k++) sb[k] = sb[k] ^ rand56() ^ 56'h1;
        build_model(24'h000001, sb);
        run_packet(24'h000001, sb, "b2b_second");
    endtask

    task automatic test_abort();
        logic [23:0]      hdr;
        logic [3:0][55:0] sb;
        random_packet(hdr, sb);
        advance(hdr, sb, 10);
        total++;
        if (packet_pixel_counter !== 5'd10) begin
            bad++;
            $display("FAIL abort_pre counter got=%0d want=10", packet_pixel_counter);
        end
        data_island_period = 1'b0;
        @(posedge clk_pixel); #1;
        check_idle_outputs("abort");
        @(posedge clk_pixel); #1;
        check_idle_outputs("abort_idle");
        random_packet(hdr, sb);
        build_model(hdr, sb);
        run_packet(hdr, sb, "after_abort");
    endtask

    task automatic test_reset_mid();
        logic [23:0]      hdr;
        logic [3:0][55:0] sb;
        random_packet(hdr, sb);
        advance(hdr, sb, 20);
        reset_n = 1'b0;
        @(posedge clk_pixel); #1;
        check_idle_outputs("reset_mid");
        random_packet(hdr, sb);
        header = hdr;
        sub    = sb;
        @(posedge clk_pixel); #1;
        check_idle_outputs("reset_over_load");
        reset_n = 1'b1;
        random_packet(hdr, sb);
        build_model(hdr, sb);
        run_packet(hdr, sb, "after_reset");
    endtask

    task automatic test_random();
        logic [23:0]      hdr;
        logic [3:0][55:0] sb;
        int               gap;
        for (int p = 0; p < 1000; p++) begin
            if (p % 50 == 49) begin
                gap = int'($urandom_range(1, 3));
                data_island_period = 1'b0;
                repeat (gap) begin
                    @(posedge clk_pixel); #1;
                end
                check_idle_outputs("random_gap");
            end
            random_packet(hdr, sb);
            build_model(hdr, sb);
            run_packet(hdr, sb, "random");
        end
    endtask

    initial begin
        reset_n            = 1'b0;
        data_island_period = 1'b0;
        header             = '0;
        sub                = '0;
        test_reset();
        test_null();
        test_header_msb();
        test_sub_msb();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
